rsa_cmd_sequencer: RTL and testbench
====================================

RSA_CMD_SEQUENCER -- requirements
Module: rsa_cmd_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1000, meaning the maximum number of clk cycles to wait for core_done after core_start.
REQ-002 SHALL have port clk, input, 1, system clock; all logic is on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high; clock clk.
REQ-004 SHALL have port rx_byte, input, 8, UART received byte.
REQ-005 SHALL have port rx_dv, input, 1, one-cycle strobe marking rx_byte valid.
REQ-006 SHALL have port core_done, input, 1, one-cycle completion pulse from the RSA core.
REQ-007 SHALL have ports p_out, q_out, e_out, m_out, output, 8 each, committed RSA operands.
REQ-008 SHALL have port core_start, output, 1, one-cycle start pulse to the RSA core.
REQ-009 SHALL have port busy, output, 1, high while waiting for core_done.
REQ-010 SHALL have port err, output, 1, sticky error flag.
REQ-011 SHALL have port err_code, output, 2, error cause: 0 none, 1 bad character, 2 format or overflow, 3 timeout.

Function
REQ-012 SHALL accept commands of the form "P,Q,E,M<CR>", with each field being 1-3 ASCII decimal digits; ','=0x2C, CR=0x0D.
REQ-013 SHALL process a byte only in a cycle with rx_dv=1; bytes are consumed at that clock edge.
REQ-014 SHALL use states PARSE (field index 0..3), START, WAIT, ERR.
REQ-015 In PARSE, SHALL handle a digit 0x30-0x39 by setting acc=acc*10+(byte-0x30) and incrementing digit_cnt; acc is at least 10 bits wide.
REQ-016 In PARSE, SHALL raise error code 2 and enter ERR on a 4th digit or on acc>255 after any digit.
REQ-017 In PARSE, on ',' with field index 0..2 and digit_cnt>=1, SHALL copy acc to the staged field, clear acc and digit_cnt, and increment the index.
REQ-018 In PARSE, on CR with field index 3 and digit_cnt>=1, SHALL stage M and go to START.
REQ-019 In PARSE, SHALL raise error code 2 and enter ERR on an empty field (delimiter with digit_cnt=0), on ',' at index 3, or on CR at index 0..2.
REQ-020 In PARSE, SHALL raise error code 1 and enter ERR on any other byte value.
REQ-021 In START, for exactly one cycle, SHALL load p_out/q_out/e_out/m_out from the staged fields, assert core_start=1, clear the timeout counter, and go to WAIT; outputs change only here.
REQ-022 In WAIT, SHALL hold busy=1 and ignore all rx_dv bytes.
REQ-023 In WAIT, on core_done=1, SHALL return to PARSE index 0.
REQ-024 In WAIT, if the counter reaches TIMEOUT-1 without core_done, SHALL raise error code 3 and go to ERR.
REQ-025 In WAIT, if core_done and the timeout boundary occur in the same cycle, core_done SHALL win.
REQ-026 In ERR, SHALL discard bytes until a CR is received, then clear acc, digit_cnt and index and return to PARSE.
REQ-027 err and err_code SHALL stay set through ERR and until the next core_start; the cycle of core_start SHALL clear both to 0.
REQ-028 On a new error while err=1, SHALL overwrite err_code with the latest cause.
REQ-029 SHALL ignore core_done outside WAIT.
REQ-030 SHALL keep core_start and busy mutually exclusive.

Reset
REQ-031 While rst=1, SHALL force state=PARSE index 0, acc=0, digit_cnt=0, staged fields=0, all outputs=0, and the timeout counter=0.
REQ-032 rst SHALL abort any state (mid-field, START, WAIT, ERR) at the next edge.
REQ-033 SHALL give rst priority over rx_dv and core_done in the same cycle.

Verification
REQ-034 Bytes "61,53,17,65<CR>" -> exactly one core_start pulse the cycle after the CR edge; p=61, q=53, e=17, m=65; busy=1 next cycle; core_done -> busy=0.
REQ-035 Bytes "256,1,1,1<CR>" -> err=1, err_code=2 at the '6' edge; following bytes ignored until CR; then "3,5,7,9<CR>" -> core_start, err cleared, p=3.
REQ-036 Bytes "1A" -> err_code=1; "1,,2,3<CR>" -> err_code=2; "1,2,3<CR>" -> err_code=2; no core_start and outputs unchanged in all three cases.
REQ-037 Valid command with TIMEOUT=8 and no core_done -> err_code=3 after 8 WAIT cycles; bytes sent during WAIT are not parsed.
REQ-038 Issue rst mid-field ("12,3" then rst) -> all outputs 0; then "9,9,9,9<CR>" parses cleanly.
REQ-039 Drive core_done on the timeout boundary cycle -> no error, state returns to PARSE.

Source files
------------

// File: rtl/rsa_cmd_sequencer.sv
// Parses "P,Q,E,M<CR>" decimal commands from a UART byte stream, commits the
// operands, starts the RSA core and supervises its completion with a timeout.
`timescale 1ns/1ps
module rsa_cmd_sequencer #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       rx_dv,
    input  logic       core_done,
    output logic [7:0] p_out,
    output logic [7:0] q_out,
    output logic [7:0] e_out,
    output logic [7:0] m_out,
    output logic       core_start,
    output logic       busy,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int unsigned ACC_W  = 10;
    localparam int unsigned PROD_W = 12;
    localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [7:0] CHAR_0     = 8'h30;
    localparam logic [7:0] CHAR_9     = 8'h39;
    localparam logic [7:0] CHAR_COMMA = 8'h2C;
    localparam logic [7:0] CHAR_CR    = 8'h0D;

    localparam logic [1:0] ERR_CHAR    = 2'd1;
    localparam logic [1:0] ERR_FORMAT  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        S_PARSE,
        S_START,
        S_WAIT,
        S_ERR
    } state_t;

    state_t            state, state_n;
    logic [1:0]        idx, idx_n;
    logic [1:0]        digit_cnt, digit_cnt_n;
    logic [ACC_W-1:0]  acc, acc_n;
    logic [7:0]        stage_p, stage_p_n;
    logic [7:0]        stage_q, stage_q_n;
    logic [7:0]        stage_e, stage_e_n;
    logic [7:0]        stage_m, stage_m_n;
    logic [CNT_W-1:0]  tmo_cnt, tmo_cnt_n;
    logic [7:0]        p_out_n, q_out_n, e_out_n, m_out_n;
    logic              core_start_n, busy_n, err_n;
    logic [1:0]        err_code_n;
    logic [PROD_W-1:0] prod;
    logic              is_digit;

    // State and all registered outputs; synchronous reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_PARSE;
            idx        <= '0;
            digit_cnt  <= '0;
            acc        <= '0;
            stage_p    <= '0;
            stage_q    <= '0;
            stage_e    <= '0;
            stage_m    <= '0;
            tmo_cnt    <= '0;
            p_out      <= '0;
            q_out      <= '0;
            e_out      <= '0;
            m_out      <= '0;
            core_start <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            err_code   <= '0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            digit_cnt  <= digit_cnt_n;
            acc        <= acc_n;
            stage_p    <= stage_p_n;
            stage_q    <= stage_q_n;
            stage_e    <= stage_e_n;
            stage_m    <= stage_m_n;
            tmo_cnt    <= tmo_cnt_n;
            p_out      <= p_out_n;
            q_out      <= q_out_n;
            e_out      <= e_out_n;
            m_out      <= m_out_n;
            core_start <= core_start_n;
            busy       <= busy_n;
            err        <= err_n;
            err_code   <= err_code_n;
        end
    end

    // Next-state, parser datapath and next values of the registered outputs
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        digit_cnt_n = digit_cnt;
        acc_n       = acc;
        stage_p_n   = stage_p;
        stage_q_n   = stage_q;
        stage_e_n   = stage_e;
        stage_m_n   = stage_m;
        tmo_cnt_n   = tmo_cnt;
        p_out_n     = p_out;
        q_out_n     = q_out;
        e_out_n     = e_out;
        m_out_n     = m_out;
        err_n       = err;
        err_code_n  = err_code;
        is_digit    = (rx_byte >= CHAR_0) && (rx_byte <= CHAR_9);
        prod        = PROD_W'(acc) * PROD_W'(10) + PROD_W'(rx_byte - CHAR_0);

        unique case (state)
            S_PARSE: begin
                if (rx_dv) begin
                    if (is_digit) begin
                        if (digit_cnt == 2'd3 || prod > PROD_W'(255)) begin
                            state_n    = S_ERR;
                            err_n      = 1'b1;
                            err_code_n = ERR_FORMAT;
                        end else begin
                            acc_n       = ACC_W'(prod);
                            digit_cnt_n = 2'(digit_cnt + 2'd1);
                        end
                    end else if (rx_byte == CHAR_COMMA) begin
                        if (digit_cnt == 2'd0 || idx == 2'd3) begin
                            state_n    = S_ERR;
                            err_n      = 1'b1;
                            err_code_n = ERR_FORMAT;
                        end else begin
                            unique case (idx)
                                2'd0:    stage_p_n = 8'(acc);
                                2'd1:    stage_q_n = 8'(acc);
                                default: stage_e_n = 8'(acc);
                            endcase
                            acc_n       = '0;
                            digit_cnt_n = '0;
                            idx_n       = 2'(idx + 2'd1);
                        end
                    end else if (rx_byte == CHAR_CR) begin
                        if (digit_cnt == 2'd0 || idx != 2'd3) begin
                            state_n    = S_ERR;
                            err_n      = 1'b1;
                            err_code_n = ERR_FORMAT;
                        end else begin
                            stage_m_n   = 8'(acc);
                            acc_n       = '0;
                            digit_cnt_n = '0;
                            idx_n       = '0;
                            state_n     = S_START;
                        end
                    end else begin
                        state_n    = S_ERR;
                        err_n      = 1'b1;
                        err_code_n = ERR_CHAR;
                    end
                end
            end
            S_START: begin
                tmo_cnt_n = '0;
                state_n   = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) begin
                    state_n = S_PARSE;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_n    = S_ERR;
                    err_n      = 1'b1;
                    err_code_n = ERR_TIMEOUT;
                end else begin
                    tmo_cnt_n = CNT_W'(tmo_cnt + CNT_W'(1));
                end
            end
            default: begin
                if (rx_dv && rx_byte == CHAR_CR) begin
                    acc_n       = '0;
                    digit_cnt_n = '0;
                    idx_n       = '0;
                    state_n     = S_PARSE;
                end
            end
        endcase

        // Outputs are registered, so the START cycle's values load on entry to START
        if (state_n == S_START) begin
            p_out_n    = stage_p_n;
            q_out_n    = stage_q_n;
            e_out_n    = stage_e_n;
            m_out_n    = stage_m_n;
            err_n      = 1'b0;
            err_code_n = '0;
        end
        core_start_n = (state_n == S_START);
        busy_n       = (state_n == S_WAIT);
    end

endmodule

// File: tb/tb_rsa_cmd_sequencer.sv
// Bench for rsa_cmd_sequencer: directed vector table, hand-written corner
// sequences and randomized byte streams, all checked every cycle against a
// line-oriented reference model.
`timescale 1ns/1ps
module tb_rsa_cmd_sequencer;

    localparam int unsigned TMO = 8;
    localparam int MP = 0, MS = 1, MW = 2, ME = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_dv = 1'b0;
    logic       core_done = 1'b0;
    logic [7:0] p_out, q_out, e_out, m_out;
    logic       core_start, busy, err;
    logic [1:0] err_code;

    rsa_cmd_sequencer #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_dv(rx_dv), .core_done(core_done),
        .p_out(p_out), .q_out(q_out), .e_out(e_out), .m_out(m_out),
        .core_start(core_start), .busy(busy), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_starts = 0;

    // Reference model state
    int         mode = MP;
    int         wait_n = 0;
    int         fv[4];
    logic [7:0] line_q[$];
    logic [7:0] m_p = 0, m_q = 0, m_e = 0, m_m = 0;
    logic       m_start = 0, m_busy = 0, m_err = 0;
    logic [1:0] m_code = 0;

    typedef struct {
        logic [127:0] txt;
        int           len;
        logic         exp_err;
        logic [1:0]   exp_code;
        logic [7:0]   p, q, e, m;
        int           exp_starts;
        int           done_wait;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    function automatic logic [63:0] dut_vec();
        return 64'({p_out, q_out, e_out, m_out, core_start, busy, err, err_code});
    endfunction

    // Validate the whole line received so far: 0 incomplete, 1/2 error cause, 4 complete
    function automatic int scan_line();
        int nf = 0, nd = 0, val = 0;
        foreach (line_q[i]) begin
            logic [7:0] b = line_q[i];
            if (b >= 8'h30 && b <= 8'h39) begin
                if (nd == 3) return 2;
                val = val * 10 + (int'(b) - 48);
                nd++;
                if (val > 255) return 2;
            end else if (b == 8'h2C) begin
                if (nd == 0 || nf == 3) return 2;
                fv[nf] = val; nf++; val = 0; nd = 0;
            end else if (b == 8'h0D) begin
                if (nd == 0 || nf != 3) return 2;
                fv[3] = val;
                return 4;
            end else begin
                return 1;
            end
        end
        return 0;
    endfunction

    function automatic void model_step();
        int r;
        if (rst) begin
            mode = MP; line_q.delete(); wait_n = 0;
            m_p = 0; m_q = 0; m_e = 0; m_m = 0;
            m_start = 0; m_busy = 0; m_err = 0; m_code = 0;
            return;
        end
        m_start = 0;
        case (mode)
            MP: if (rx_dv) begin
                line_q.push_back(rx_byte);
                r = scan_line();
                if (r == 1 || r == 2) begin
                    m_err = 1; m_code = 2'(r); mode = ME; line_q.delete();
                end else if (r == 4) begin
                    m_p = 8'(fv[0]); m_q = 8'(fv[1]); m_e = 8'(fv[2]); m_m = 8'(fv[3]);
                    m_start = 1; m_err = 0; m_code = 0; mode = MS; line_q.delete();
                end
            end
            MS: begin mode = MW; wait_n = 0; end
            MW: begin
                if (core_done) mode = MP;
                else begin
                    wait_n++;
                    if (wait_n == int'(TMO)) begin m_err = 1; m_code = 3; mode = ME; end
                end
            end
            default: if (rx_dv && rx_byte == 8'h0D) mode = MP;
        endcase
        m_busy = (mode == MW);
    endfunction

    // One clock: model follows the edge, DUT compared 1ns later
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("cycle", dut_vec(),
              64'({m_p, m_q, m_e, m_m, m_start, m_busy, m_err, m_code}));
        if (core_start) n_starts++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dv = 1'b1; rx_byte = b;
        tick();
        rx_dv = 1'b0; rx_byte = 8'h00;
    endtask

    task automatic send_text(input logic [127:0] txt, input int len);
        for (int i = 0; i < len; i++) send_byte(txt[8*(len-1-i) +: 8]);
    endtask

    task automatic pulse_done();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
    endtask

    task automatic gen_cmd(inout logic [7:0] pend[$]);
        string s = "";
        for (int f = 0; f < 4; f++) begin
            int v = int'($urandom_range(0, 299));
            if ($urandom_range(0, 4) == 0) s = {s, $sformatf("%03d", v)};
            else                          s = {s, $sformatf("%0d", v)};
            if (f < 3) s = {s, ","};
        end
        s = {s, "\r"};
        for (int i = 0; i < s.len(); i++) begin
            int r = int'($urandom_range(0, 99));
            if (r < 3) continue;
            else if (r < 6) pend.push_back(8'($urandom_range(0, 255)));
            else pend.push_back(s[i]);
        end
    endtask

    initial begin
        logic [7:0] pend[$];
        int starts_before;

        vecs[0] = '{"61,53,17,65\r",   12, 1'b0, 2'd0, 8'd61, 8'd53, 8'd17, 8'd65, 1, 3};
        vecs[1] = '{"256,1,1,1\r",     10, 1'b1, 2'd2, 8'd61, 8'd53, 8'd17, 8'd65, 0, 0};
        vecs[2] = '{"3,5,7,9\r",        8, 1'b0, 2'd0, 8'd3,  8'd5,  8'd7,  8'd9,  1, 2};
        vecs[3] = '{"1A\r",             3, 1'b1, 2'd1, 8'd3,  8'd5,  8'd7,  8'd9,  0, 0};
        vecs[4] = '{"1,,2,3\r",         7, 1'b1, 2'd2, 8'd3,  8'd5,  8'd7,  8'd9,  0, 0};
        vecs[5] = '{"1,2,3\r\r",        7, 1'b1, 2'd2, 8'd3,  8'd5,  8'd7,  8'd9,  0, 0};
        vecs[6] = '{"1234,1,1,1\r",    11, 1'b1, 2'd2, 8'd3,  8'd5,  8'd7,  8'd9,  0, 0};
        vecs[7] = '{"0,255,007,1\r",   12, 1'b0, 2'd0, 8'd0,  8'd255, 8'd7, 8'd1,  1, 8};
        vecs[8] = '{"1,2,3,4,\r",       9, 1'b1, 2'd2, 8'd0,  8'd255, 8'd7, 8'd1,  0, 0};

        // Reset state
        rst = 1'b1;
        tick(); tick();
        check("reset_outputs", dut_vec(), 64'd0);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            starts_before = n_starts;
            send_text(vecs[i].txt, vecs[i].len);
            check($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
            check($sformatf("v%0d_err_code", i), 64'(err_code), 64'(vecs[i].exp_code));
            check($sformatf("v%0d_operands", i), 64'({p_out, q_out, e_out, m_out}),
                  64'({vecs[i].p, vecs[i].q, vecs[i].e, vecs[i].m}));
            check($sformatf("v%0d_starts", i), 64'(n_starts - starts_before),
                  64'(vecs[i].exp_starts));
            if (vecs[i].exp_starts > 0) begin
                repeat (vecs[i].done_wait) tick();
                check($sformatf("v%0d_busy_before_done", i), 64'(busy), 64'd1);
                pulse_done();
                check($sformatf("v%0d_busy_after_done", i), 64'(busy), 64'd0);
                check($sformatf("v%0d_err_after_done", i), 64'(err), 64'd0);
            end
        end

        // Timeout with bytes arriving during WAIT
        send_text("1,2,3,4\r", 8);
        check("tmo_start", 64'(core_start), 64'd1);
        begin
            logic [127:0] junk = "77,77,77\r";
            for (int k = 1; k <= 9; k++) begin
                send_byte(junk[8*(9-k) +: 8]);
                if (k == 8) check("tmo_not_yet", 64'({busy, err}), 64'b10);
            end
        end
        check("tmo_err", 64'({busy, err, err_code}), 64'b0_1_11);
        send_byte(8'h0D);
        check("tmo_no_parse", 64'({p_out, q_out, e_out, m_out}), 64'h01020304);
        check("tmo_sticky", 64'({err, err_code}), 64'b1_11);

        // Reset in the middle of a field
        send_text("12,3", 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_midfield", dut_vec(), 64'd0);
        send_text("9,9,9,9\r", 8);
        check("after_rst_cmd", 64'({p_out, q_out, e_out, m_out, core_start}),
              64'({8'd9, 8'd9, 8'd9, 8'd9, 1'b1}));
        tick();
        pulse_done();

        // Reset beats core_done and a byte in the same WAIT cycle
        send_text("5,6,7,8\r", 8);
        tick();
        check("prio_in_wait", 64'(busy), 64'd1);
        rst = 1'b1; core_done = 1'b1; rx_dv = 1'b1; rx_byte = 8'h0D;
        tick();
        rst = 1'b0; core_done = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00;
        check("prio_rst", dut_vec(), 64'd0);
        tick();
        check("prio_quiet", dut_vec(), 64'd0);

        // Randomized streams against the model
        for (int c = 0; c < 4000; c++) begin
            if (pend.size() == 0) gen_cmd(pend);
            rx_dv = ($urandom_range(0, 3) != 0);
            if (rx_dv) rx_byte = pend.pop_front();
            else       rx_byte = 8'($urandom_range(0, 255));
            if (mode == MW) core_done = ($urandom_range(0, 5) == 0);
            else            core_done = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
            rx_dv = 1'b0; core_done = 1'b0; rst = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
